// File: rtl/disp_pkg_amisha.sv
// Shared constants for the multiplexed hex display: segment codes, the
// all-off pattern and default sizing.
package disp_pkg_amisha;

  localparam int N_DIGITS_DEF = 4;
  localparam int PRESC_W_DEF  = 18;

  // Active-low {dp, g..a}; all ones means every segment dark.
  localparam logic [7:0] SSEG_OFF  = 8'hFF;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

endpackage

// File: rtl/hex_to_sseg_amisha.sv
// Combinational nibble to active-low seven-segment decoder (bits 6..0 = g..a).
module hex_to_sseg_amisha
  import disp_pkg_amisha::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (hex)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/disp_hex_mux_n_amisha.sv
// Time-multiplexed N-digit hex display driver with double-buffered data,
// leading-zero blanking and PWM brightness on the anode enables.
module disp_hex_mux_n_amisha
  import disp_pkg_amisha::*;
#(
  parameter int N_DIGITS = N_DIGITS_DEF,
  parameter int PRESC_W  = PRESC_W_DEF
) (
  input  logic                  clk_amisha,
  input  logic                  reset_amisha,
  input  logic                  load_amisha,
  input  logic [4*N_DIGITS-1:0] hex_in_amisha,
  input  logic [N_DIGITS-1:0]   dp_in_amisha,
  input  logic                  lz_blank_amisha,
  input  logic [3:0]            bright_amisha,
  input  logic                  en_amisha,
  output logic [N_DIGITS-1:0]   an_amisha,
  output logic [7:0]            sseg_amisha,
  output logic                  frame_amisha
);

  localparam int IDX_W = (N_DIGITS > 2) ? $clog2(N_DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  logic [PRESC_W-1:0]    presc_p0;
  logic [IDX_W-1:0]      idx_p0;
  logic [4*N_DIGITS-1:0] pend_hex_p0, act_hex_p0;
  logic [N_DIGITS-1:0]   pend_dp_p0, act_dp_p0;
  logic                  tick, wrap;

  logic [N_DIGITS-1:0]   blank;
  logic                  zero_run;
  logic [3:0]            nib_sel;
  logic [6:0]            seg_sel;
  logic                  duty_on;
  logic [N_DIGITS-1:0]   an_next;
  logic [7:0]            sseg_next;

  logic [N_DIGITS-1:0]   an_p1;
  logic [7:0]            sseg_p1;
  logic                  frame_p1;

  assign tick = &presc_p0;
  assign wrap = tick && (idx_p0 == IDX_LAST);

  // Stage 0: scan counters and the pending/active buffer pair
  always_ff @(posedge clk_amisha or negedge reset_amisha) begin
    if (!reset_amisha) begin
      presc_p0    <= '0;
      idx_p0      <= '0;
      pend_hex_p0 <= '0;
      pend_dp_p0  <= '0;
      act_hex_p0  <= '0;
      act_dp_p0   <= '0;
    end else begin
      presc_p0 <= presc_p0 + 1'b1;
      if (tick)
        idx_p0 <= wrap ? '0 : idx_p0 + 1'b1;
      // Active copy is taken only at the frame wrap, so a frame never tears;
      // a coincident load lands in pending and shows one frame later.
      if (wrap) begin
        act_hex_p0 <= pend_hex_p0;
        act_dp_p0  <= pend_dp_p0;
      end
      if (load_amisha) begin
        pend_hex_p0 <= hex_in_amisha;
        pend_dp_p0  <= dp_in_amisha;
      end
    end
  end

  // A digit blanks when it and every digit above it are zero; digit 0 never does.
  always_comb begin
    blank    = '0;
    zero_run = 1'b1;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      zero_run = zero_run && (act_hex_p0[4*k +: 4] == 4'h0);
      blank[k] = lz_blank_amisha && zero_run;
    end
  end

  assign nib_sel = act_hex_p0[4*idx_p0 +: 4];

  hex_to_sseg_amisha u_dec (
    .hex (nib_sel),
    .seg (seg_sel)
  );

  // Top four prescaler bits form the PWM phase within the slot.
  assign duty_on = (presc_p0[PRESC_W-1 -: 4] <= bright_amisha);

  always_comb begin
    an_next = '1;
    if (en_amisha && duty_on)
      an_next[idx_p0] = 1'b0;
    sseg_next = {~act_dp_p0[idx_p0], blank[idx_p0] ? SEG_BLANK : seg_sel};
  end

  // Stage 1: registered display outputs and frame pulse
  always_ff @(posedge clk_amisha or negedge reset_amisha) begin
    if (!reset_amisha) begin
      an_p1    <= '1;
      sseg_p1  <= SSEG_OFF;
      frame_p1 <= 1'b0;
    end else begin
      an_p1    <= an_next;
      sseg_p1  <= sseg_next;
      frame_p1 <= wrap;
    end
  end

  assign an_amisha    = an_p1;
  assign sseg_amisha  = sseg_p1;
  assign frame_amisha = frame_p1;

endmodule

// File: tb/tb_disp_hex_mux_n_amisha.sv
// Bench for disp_hex_mux_n_amisha (4 digits, 16-cycle slots) against a
// cycle-count based reference model.
module tb_disp_hex_mux_n_amisha;

  localparam int ND    = 4;
  localparam int PW    = 4;
  localparam int SLOT  = 1 << PW;
  localparam int FRAME = ND * SLOT;

  logic          clk_amisha = 1'b0;
  logic          reset_amisha;
  logic          load_amisha;
  logic [4*ND-1:0] hex_in_amisha;
  logic [ND-1:0] dp_in_amisha;
  logic          lz_blank_amisha;
  logic [3:0]    bright_amisha;
  logic          en_amisha;
  logic [ND-1:0] an_amisha;
  logic [7:0]    sseg_amisha;
  logic          frame_amisha;

  disp_hex_mux_n_amisha #(.N_DIGITS(ND), .PRESC_W(PW)) dut (
    .clk_amisha      (clk_amisha),
    .reset_amisha    (reset_amisha),
    .load_amisha     (load_amisha),
    .hex_in_amisha   (hex_in_amisha),
    .dp_in_amisha    (dp_in_amisha),
    .lz_blank_amisha (lz_blank_amisha),
    .bright_amisha   (bright_amisha),
    .en_amisha       (en_amisha),
    .an_amisha       (an_amisha),
    .sseg_amisha     (sseg_amisha),
    .frame_amisha    (frame_amisha)
  );

  always #5 clk_amisha = ~clk_amisha;

  int n_chk = 0;
  int n_bad = 0;

  // Reference model state: edges since reset release plus the two buffers.
  int unsigned     cyc;
  logic [4*ND-1:0] m_pend_hex, m_act_hex;
  logic [ND-1:0]   m_pend_dp, m_act_dp;
  logic [ND-1:0]   exp_an;
  logic [7:0]      exp_sseg;
  logic            exp_frame;
  logic [6:0]      seg_tbl [16];
  int              frames;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_sseg(input logic [4*ND-1:0] hex, input logic [ND-1:0] dp,
                                          input int dig, input logic lz);
    int hi;
    logic [3:0] nib;
    hi = -1;
    for (int k = 0; k < ND; k++)
      if (hex[4*k +: 4] != 4'h0) hi = k;
    nib = hex[4*dig +: 4];
    if (lz && dig > 0 && dig > hi)
      return {~dp[dig], 7'b1111111};
    return {~dp[dig], seg_tbl[nib]};
  endfunction

  // Predict what the next rising edge produces, using the inputs now applied.
  task automatic model_step();
    int slot, dig, level;
    slot  = int'(cyc % SLOT);
    dig   = int'((cyc / SLOT) % ND);
    level = slot >> (PW - 4);
    exp_an = '1;
    if (en_amisha && level <= int'(bright_amisha))
      exp_an[dig] = 1'b0;
    exp_sseg  = ref_sseg(m_act_hex, m_act_dp, dig, lz_blank_amisha);
    exp_frame = ((cyc + 1) % FRAME) == 0;
    if (exp_frame) begin
      m_act_hex = m_pend_hex;
      m_act_dp  = m_pend_dp;
    end
    if (load_amisha) begin
      m_pend_hex = hex_in_amisha;
      m_pend_dp  = dp_in_amisha;
    end
    cyc++;
  endtask

  task automatic step();
    model_step();
    @(negedge clk_amisha);
    check_eq("an", an_amisha, exp_an);
    check_eq("sseg", sseg_amisha, exp_sseg);
    check_eq("frame", frame_amisha, exp_frame);
    if (frame_amisha) frames++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_load(input logic [4*ND-1:0] h, input logic [ND-1:0] d);
    hex_in_amisha = h;
    dp_in_amisha  = d;
    load_amisha   = 1'b1;
    step();
    load_amisha   = 1'b0;
  endtask

  // Called at a negedge: asserts reset between edges, checks the immediate
  // effect, then releases on the following negedge.
  task automatic apply_reset();
    #2 reset_amisha = 1'b0;
    #1;
    check_eq("rst_an", an_amisha, {ND{1'b1}});
    check_eq("rst_sseg", sseg_amisha, 8'hFF);
    check_eq("rst_frame", frame_amisha, 1'b0);
    cyc = 0;
    m_pend_hex = '0; m_act_hex = '0;
    m_pend_dp  = '0; m_act_dp  = '0;
    @(negedge clk_amisha);
    check_eq("rst_hold_an", an_amisha, {ND{1'b1}});
    reset_amisha = 1'b1;
  endtask

  initial begin
    int lowc, first, cnt;
    seg_tbl[0]  = 7'b1000000; seg_tbl[1]  = 7'b1111001; seg_tbl[2]  = 7'b0100100;
    seg_tbl[3]  = 7'b0110000; seg_tbl[4]  = 7'b0011001; seg_tbl[5]  = 7'b0010010;
    seg_tbl[6]  = 7'b0000010; seg_tbl[7]  = 7'b1111000; seg_tbl[8]  = 7'b0000000;
    seg_tbl[9]  = 7'b0010000; seg_tbl[10] = 7'b0001000; seg_tbl[11] = 7'b0000011;
    seg_tbl[12] = 7'b1000110; seg_tbl[13] = 7'b0100001; seg_tbl[14] = 7'b0000110;
    seg_tbl[15] = 7'b0001110;

    reset_amisha    = 1'b1;
    load_amisha     = 1'b0;
    hex_in_amisha   = '0;
    dp_in_amisha    = '0;
    lz_blank_amisha = 1'b0;
    bright_amisha   = 4'd15;
    en_amisha       = 1'b1;
    @(negedge clk_amisha);
    apply_reset();

    // Free-running scan after release: digit 0 first, two frames in 130 cycles
    frames = 0;
    step();
    check_eq("first_an", an_amisha, 4'b1110);
    check_eq("first_sseg", sseg_amisha, 8'b11000000);
    run(129);
    check_eq("frame_cnt", frames, 2);

    // Mid-frame load is held back until the next wrap
    run(7);
    do_load(16'h00A3, 4'b0100);
    run(200);

    // Leading-zero blanking, then an all-zero value
    lz_blank_amisha = 1'b1;
    run(130);
    do_load(16'h0000, 4'b0000);
    run(200);
    lz_blank_amisha = 1'b0;

    // PWM: bright=3 lights a quarter of each slot; en=0 keeps anodes dark
    bright_amisha = 4'd3;
    run(5);
    lowc = 0;
    repeat (FRAME) begin
      step();
      if (an_amisha !== 4'hF) lowc++;
    end
    check_eq("duty_b3", lowc, FRAME / 4);
    en_amisha = 1'b0;
    step();
    lowc = 0;
    repeat (FRAME) begin
      step();
      if (an_amisha !== 4'hF) lowc++;
    end
    check_eq("en_off", lowc, 0);
    en_amisha     = 1'b1;
    bright_amisha = 4'd15;

    // Load exactly on the wrap edge with 2222 already pending
    do_load(16'h2222, 4'b0000);
    while ((cyc % FRAME) != FRAME - 1) step();
    do_load(16'h1111, 4'b0000);
    run(2 * FRAME + 2);

    // Randomized operation
    repeat (1500) begin
      if ($urandom_range(15) == 0) lz_blank_amisha = 1'($urandom);
      if ($urandom_range(31) == 0) bright_amisha = 4'($urandom);
      if ($urandom_range(63) == 0) en_amisha = ($urandom_range(3) != 0);
      if ($urandom_range(24) == 0)
        do_load(16'($urandom), 4'($urandom));
      else
        step();
    end

    // Reset mid-slot on digit 2 discards pending data and restarts the scan
    lz_blank_amisha = 1'b0;
    bright_amisha   = 4'd15;
    en_amisha       = 1'b1;
    do_load(16'h5678, 4'b1111);
    while ((cyc % FRAME) != 2 * SLOT + 7) step();
    apply_reset();
    first = -1;
    cnt   = 0;
    repeat (FRAME + 10) begin
      step();
      cnt++;
      if (frame_amisha && first < 0) first = cnt;
    end
    check_eq("first_frame", first, FRAME);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
